adder_bist_engine: RTL

//  Synthesisable self-checking stimulus/compare engine for the adder family (prefix, Ling, Jackson).

---
 rtl/adder_bist_pkg.sv | 54 +++++
 rtl/adder_bist_prng.sv | 33 +++
 rtl/adder_bist_engine.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/adder_bist_pkg.sv
// Shared encodings and helpers for the adder BIST engine: modes, FSM states, seed, corner table, PRNG step.
// Pure declarations; no latency or flow control of its own.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    MODE_RANDOM  = 2'd0,
    MODE_EXHAUST = 2'd1,
    MODE_CORNER  = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [63:0] DEFAULT_SEED = 64'h9E37_79B9_7F4A_7C15;

  // Operand pair carried at full 64-bit width; users keep the low WIDTH bits.
  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
  } pair_t;

  function automatic logic [63:0] xorshift64(input logic [63:0] s);
    logic [63:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  function automatic pair_t corner_pair(input int width, input logic [2:0] idx);
    logic [63:0] ones;
    logic [63:0] msb;
    pair_t       p;
    ones = 64'hFFFF_FFFF_FFFF_FFFF;
    msb  = 64'd1 << (width - 1);
    unique case (idx)
      3'd0:    begin p.a = 64'd0;                 p.b = 64'd0;                 end
      3'd1:    begin p.a = ones;                  p.b = 64'd1;                 end
      3'd2:    begin p.a = ones;                  p.b = ones;                  end
      3'd3:    begin p.a = msb;                   p.b = msb;                   end
      3'd4:    begin p.a = 64'h5555_5555_5555_5555; p.b = 64'hAAAA_AAAA_AAAA_AAAA; end
      3'd5:    begin p.a = 64'h5555_5555_5555_5555; p.b = 64'h5555_5555_5555_5555; end
      3'd6:    begin p.a = 64'd1;                 p.b = ones;                  end
      default: begin p.a = ones;                  p.b = 64'd0;                 end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/adder_bist_prng.sv
// xorshift64 operand source: two steps per issued vector, seed loaded when a run is accepted.
// a/b are combinational from the current (or freshly loaded) state; state advances on adv, no stall.
// No backpressure: the engine advances it once per issue cycle.
module adder_bist_prng
  import adder_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  input  logic [63:0] seed,
  output logic [63:0] a,
  output logic [63:0] b
);

  logic [63:0] s_q;
  logic [63:0] base;

  // On the accepting edge the first pair is drawn straight from the new seed.
  always_comb begin
    base = s_q;
    if (load) base = (seed == 64'd0) ? DEFAULT_SEED : seed;
    a = xorshift64(base);
    b = xorshift64(a);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       s_q <= 64'd0;
    else if (adv)  s_q <= b;
    else if (load) s_q <= base;
  end

endmodule

// File: rtl/adder_bist_engine.sv
// Adder BIST: issues one operand pair per cycle to NUM_DUT adders and checks sums against a+b mod 2^WIDTH.
// First compare DUT_LAT+1 cycles after the run-entry edge; done DUT_LAT+1 cycles after the last issue.
// No backpressure: DUTs must accept every cycle; start is ignored while busy.
module adder_bist_engine
  import adder_bist_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int NUM_DUT = 4,
  parameter int DUT_LAT = 0,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [CNT_W-1:0]         num_vec,
  input  logic [63:0]              seed,
  output logic [WIDTH-1:0]         op_a,
  output logic [WIDTH-1:0]         op_b,
  input  logic [NUM_DUT*WIDTH-1:0] dut_sum,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_DUT-1:0]       pass_mask,
  output logic [NUM_DUT*CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0]         vec_cnt
);

  state_e           state_q, state_d;
  logic             accept, issue;
  logic [1:0]       mode_q, mode_sel;
  logic [CNT_W-1:0] nvec_q, issue_cnt, idx;
  logic [2:0]       drain_cnt;

  logic [63:0]      prng_a, prng_b, idx64, nxt_a, nxt_b;
  pair_t            cp;
  logic             unused_bits;

  logic [DUT_LAT:0] gold_vld;
  logic [WIDTH-1:0] gold_dat [DUT_LAT+1];
  logic [CNT_W-1:0] fail_q   [NUM_DUT];
  logic [CNT_W-1:0] fail_nxt [NUM_DUT];
  logic [NUM_DUT-1:0] pass_nxt;

  // The accepting edge already issues vector 0, so a 1-vector run goes straight to DRAIN.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done    = (state_q == ST_DONE);
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept = 1'b1;
          if (num_vec == '0) begin
            state_d = ST_DRAIN;
          end else begin
            issue   = 1'b1;
            state_d = (num_vec == CNT_W'(1)) ? ST_DRAIN : ST_RUN;
          end
        end
      end
      ST_RUN: begin
        issue = 1'b1;
        if (issue_cnt + CNT_W'(1) == nvec_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt == 3'(DUT_LAT)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  adder_bist_prng u_prng (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .adv  (issue),
    .seed (seed),
    .a    (prng_a),
    .b    (prng_b)
  );

  // Inputs are used live on the accepting edge, registered copies afterwards.
  always_comb begin
    mode_sel = accept ? mode : mode_q;
    idx      = accept ? '0 : issue_cnt;
    idx64    = 64'(idx);
    cp       = corner_pair(WIDTH, idx[2:0]);
    unique case (mode_e'(mode_sel))
      MODE_EXHAUST: begin
        nxt_a = idx64 & ((64'd1 << (WIDTH / 2)) - 64'd1);
        nxt_b = idx64 >> (WIDTH / 2);
      end
      MODE_CORNER: begin
        nxt_a = cp.a;
        nxt_b = cp.b;
      end
      default: begin
        nxt_a = prng_a;
        nxt_b = prng_b;
      end
    endcase
  end

  assign unused_bits = ^{nxt_a, nxt_b};

  always_comb begin
    for (int k = 0; k < NUM_DUT; k++) begin
      fail_nxt[k] = fail_q[k];
      if (gold_vld[DUT_LAT] && (dut_sum[k*WIDTH +: WIDTH] != gold_dat[DUT_LAT]) &&
          (fail_q[k] != '1))
        fail_nxt[k] = fail_q[k] + CNT_W'(1);
      pass_nxt[k] = (fail_nxt[k] == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= 2'd0;
      nvec_q    <= '0;
      issue_cnt <= '0;
      drain_cnt <= 3'd0;
      op_a      <= '0;
      op_b      <= '0;
      gold_vld  <= '0;
      for (int i = 0; i <= DUT_LAT; i++) gold_dat[i] <= '0;
      for (int k = 0; k < NUM_DUT; k++) fail_q[k] <= '0;
      vec_cnt   <= '0;
      pass_mask <= '0;
    end else begin
      drain_cnt <= (state_q == ST_DRAIN) ? drain_cnt + 3'd1 : 3'd0;

      gold_vld[0] <= issue;
      gold_dat[0] <= nxt_a[WIDTH-1:0] + nxt_b[WIDTH-1:0];
      for (int i = 1; i <= DUT_LAT; i++) begin
        gold_vld[i] <= gold_vld[i-1];
        gold_dat[i] <= gold_dat[i-1];
      end

      for (int k = 0; k < NUM_DUT; k++) fail_q[k] <= fail_nxt[k];
      if (gold_vld[DUT_LAT]) vec_cnt <= vec_cnt + CNT_W'(1);

      if (issue) begin
        op_a      <= nxt_a[WIDTH-1:0];
        op_b      <= nxt_b[WIDTH-1:0];
        issue_cnt <= idx + CNT_W'(1);
      end

      // The delay line is empty in IDLE/DONE, so clearing here never drops a compare.
      if (accept) begin
        mode_q  <= mode;
        nvec_q  <= num_vec;
        vec_cnt <= '0;
        for (int k = 0; k < NUM_DUT; k++) fail_q[k] <= '0;
        if (!issue) issue_cnt <= '0;
      end

      if ((state_q == ST_DRAIN) && (state_d == ST_DONE)) pass_mask <= pass_nxt;
    end
  end

  for (genvar k = 0; k < NUM_DUT; k++) begin : g_fail
    assign fail_cnt[k*CNT_W +: CNT_W] = fail_q[k];
  end

endmodule
